// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I decode with a DEPTH-entry skid FIFO toward execute.
// Fields, format and sign-extended immediate are resolved before queuing.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          last_q;
  ent_t          head;
  ent_t          dec;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [6:0]    op;
  logic [31:0]   imm32;

  assign op = in_instr[6:0];

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
    imm32     = '0;
    unique case (1'b1)
      (op == 7'b0110111),
      (op == 7'b0010111): dec.fmt = 3'd4;
      (op == 7'b1101111): dec.fmt = 3'd5;
      (op == 7'b1100111) && (in_instr[14:12] == 3'b000),
      (op == 7'b0000011),
      (op == 7'b0010011),
      (op == 7'b0001111),
      (op == 7'b1110011): dec.fmt = 3'd1;
      (XLEN == 64) && (op == 7'b0011011): dec.fmt = 3'd1;
      (op == 7'b1100011): dec.fmt = 3'd3;
      (op == 7'b0100011): dec.fmt = 3'd2;
      (op == 7'b0110011): dec.fmt = 3'd0;
      (XLEN == 64) && (op == 7'b0111011): dec.fmt = 3'd0;
      default: dec.fmt = 3'd7;
    endcase
    unique case (dec.fmt)
      3'd1: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'd2: imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                     in_instr[11:7]};
      3'd3: imm32 = {{19{in_instr[31]}}, in_instr[31],
                     in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      3'd4: imm32 = {in_instr[31:12], 12'b0};
      3'd5: imm32 = {{11{in_instr[31]}}, in_instr[31],
                     in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = (dec.fmt == 3'd7);
  end

  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // An empty FIFO keeps presenting the most recently popped entry.
  assign head = out_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign out_pc      = head.pc;
  assign out_opcode  = head.instr[6:0];
  assign out_rd      = head.instr[11:7];
  assign out_rs1     = head.instr[19:15];
  assign out_rs2     = head.instr[24:20];
  assign out_funct3  = head.instr[14:12];
  assign out_funct7  = head.instr[31:25];
  assign out_fmt     = head.fmt;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench driving an RV64 and an RV32 decode_stage
// with identical beats; a negedge monitor checks occupancy and every pop.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  always #5 clk = ~clk;

  logic        a_ir, a_ov, a_ill;
  logic [31:0] a_pc;
  logic [6:0]  a_op, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_fmt;
  logic [63:0] a_imm;

  logic        b_ir, b_ov, b_ill;
  logic [31:0] b_pc;
  logic [6:0]  b_op, b_f7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3, b_fmt;
  logic [31:0] b_imm;

  decode_stage #(.XLEN(64), .PC_W(32), .DEPTH(2)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ir),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_rd(a_rd),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3),
    .out_funct7(a_f7), .out_fmt(a_fmt), .out_imm(a_imm),
    .out_illegal(a_ill)
  );

  decode_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_ir),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_op), .out_rd(b_rd),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3),
    .out_funct7(b_f7), .out_fmt(b_fmt), .out_imm(b_imm),
    .out_illegal(b_ill)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic [2:0]  f32;
    logic [31:0] i32;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t cur;
  exp_t q[$];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] pc,
                              input logic [2:0] f64, input logic [63:0] i64,
                              input logic [2:0] f32, input logic [31:0] i32);
    exp_t e;
    e.instr = i; e.pc = pc;
    e.f64 = f64; e.i64 = i64;
    e.f32 = f32; e.i32 = i32;
    return e;
  endfunction

  // Reference decoder for the random stream, built from arithmetic shifts.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t        e;
    longint      s;
    logic [63:0] v;
    logic [2:0]  f;
    s = longint'($signed(i));
    case (i[6:0])
      7'h37, 7'h17: f = 3'd4;
      7'h6F: f = 3'd5;
      7'h67: f = (i[14:12] == 3'd0) ? 3'd1 : 3'd7;
      7'h03, 7'h13, 7'h0F, 7'h73, 7'h1B: f = 3'd1;
      7'h63: f = 3'd3;
      7'h23: f = 3'd2;
      7'h33, 7'h3B: f = 3'd0;
      default: f = 3'd7;
    endcase
    case (f)
      3'd1: v = 64'(s >>> 20);
      3'd2: v = 64'(((s >>> 25) << 5) | longint'(i[11:7]));
      3'd3: v = 64'(((s >>> 31) << 12) | (longint'(i[7]) << 11)
                | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1));
      3'd4: v = 64'((s >>> 12) << 12);
      3'd5: v = 64'(((s >>> 31) << 20) | (longint'(i[19:12]) << 12)
                | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1));
      default: v = '0;
    endcase
    e.instr = i; e.pc = pc;
    e.f64 = f; e.i64 = v;
    if (i[6:0] == 7'h1B || i[6:0] == 7'h3B) begin
      e.f32 = 3'd7; e.i32 = '0;
    end else begin
      e.f32 = f; e.i32 = v[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("valid64", 64'(a_ov), 64'(q.size() != 0));
      chk("valid32", 64'(b_ov), 64'(q.size() != 0));
      chk("ready64", 64'(a_ir), 64'(q.size() < 2));
      chk("ready32", 64'(b_ir), 64'(q.size() < 2));
      if (a_ov && out_ready && !flush && q.size() != 0) begin
        e = q.pop_front();
        chk("pc64", 64'(a_pc), 64'(e.pc));
        chk("opcode", 64'(a_op), 64'(e.instr[6:0]));
        chk("rd", 64'(a_rd), 64'(e.instr[11:7]));
        chk("rs1", 64'(a_rs1), 64'(e.instr[19:15]));
        chk("rs2", 64'(a_rs2), 64'(e.instr[24:20]));
        chk("funct3", 64'(a_f3), 64'(e.instr[14:12]));
        chk("funct7", 64'(a_f7), 64'(e.instr[31:25]));
        chk("fmt64", 64'(a_fmt), 64'(e.f64));
        chk("imm64", a_imm, e.i64);
        chk("ill64", 64'(a_ill), 64'(e.f64 == 3'd7));
        chk("pc32", 64'(b_pc), 64'(e.pc));
        chk("fmt32", 64'(b_fmt), 64'(e.f32));
        chk("imm32", 64'(b_imm), 64'(e.i32));
        chk("ill32", 64'(b_ill), 64'(e.f32 == 3'd7));
      end
      if (in_valid && a_ir && !flush) q.push_back(cur);
      if (flush) q.delete();
    end
  end

  task automatic put(input exp_t e);
    in_instr = e.instr;
    in_pc    = e.pc;
    cur      = e;
    in_valid = 1'b1;
  endtask

  task automatic wait_acc();
    bit acc;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_valid && a_ir && !flush;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout t=%0t", $time);
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F,
                           7'h73, 7'h63, 7'h23, 7'h33, 7'h1B, 7'h3B};

  initial begin
    bit          pending;
    bit          acc;
    int          n_acc;
    logic [31:0] r;
    logic [31:0] pc;

    cycles(2);
    chk("rst_valid", 64'(a_ov), 64'd0);
    chk("rst_ready", 64'(a_ir), 64'd1);
    chk("rst_imm", a_imm, 64'd0);
    chk("rst_pc", 64'(a_pc), 64'd0);
    chk("rst_fmt", 64'(a_fmt), 64'd0);
    chk("rst_rd", 64'(a_rd), 64'd0);
    rst_n = 1'b1;
    cycles(1);

    // addi x1,x0,-1: visible the cycle after the push
    out_ready = 1'b1;
    put(mk(32'hFFF00093, 32'h100, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF,
           3'd1, 32'hFFFF_FFFF));
    wait_acc();
    chk("t1_valid", 64'(a_ov), 64'd1);
    chk("t1_rd", 64'(a_rd), 64'd1);
    cycles(1);
    chk("hold_pc", 64'(a_pc), 64'h100);
    chk("hold_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // format and immediate vectors, back to back
    put(mk(32'hFE000EE3, 32'h104, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC,
           3'd3, 32'hFFFF_FFFC));
    wait_acc();
    put(mk(32'h800000B7, 32'h108, 3'd4, 64'hFFFF_FFFF_8000_0000,
           3'd4, 32'h8000_0000));
    wait_acc();
    put(mk(32'h0020A423, 32'h10C, 3'd2, 64'd8, 3'd2, 32'd8));
    wait_acc();
    put(mk(32'h001000EF, 32'h110, 3'd5, 64'h800, 3'd5, 32'h800));
    wait_acc();
    put(mk(32'h002081B3, 32'h114, 3'd0, 64'd0, 3'd0, 32'd0));
    wait_acc();
    put(mk(32'h0050009B, 32'h118, 3'd1, 64'd5, 3'd7, 32'd0));
    wait_acc();
    put(mk(32'h002081BB, 32'h11C, 3'd0, 64'd0, 3'd7, 32'd0));
    wait_acc();
    put(mk(32'h00000073, 32'h120, 3'd1, 64'd0, 3'd1, 32'd0));
    wait_acc();
    put(mk(32'h00000000, 32'h124, 3'd7, 64'd0, 3'd7, 32'd0));
    wait_acc();
    put(mk(32'h000010E7, 32'h128, 3'd7, 64'd0, 3'd7, 32'd0));
    wait_acc();
    put(mk(32'hFFF00091, 32'h12C, 3'd7, 64'd0, 3'd7, 32'd0));
    wait_acc();
    cycles(3);
    chk("t2_drain", 64'(q.size()), 64'd0);

    // back-pressure: third beat held while full
    out_ready = 1'b0;
    put(mk(32'h00100093, 32'h200, 3'd1, 64'd1, 3'd1, 32'd1));
    wait_acc();
    put(mk(32'h00200093, 32'h204, 3'd1, 64'd2, 3'd1, 32'd2));
    wait_acc();
    chk("t3_full", 64'(a_ir), 64'd0);
    put(mk(32'h00300093, 32'h208, 3'd1, 64'd3, 3'd1, 32'd3));
    cycles(2);
    chk("t3_held", 64'(a_ir), 64'd0);
    chk("t3_headpc", 64'(a_pc), 64'h200);
    out_ready = 1'b1;
    wait_acc();
    cycles(3);
    chk("t3_drain", 64'(q.size()), 64'd0);

    // flush with a full FIFO and a live input beat
    out_ready = 1'b0;
    put(mk(32'h00400093, 32'h300, 3'd1, 64'd4, 3'd1, 32'd4));
    wait_acc();
    put(mk(32'h00500093, 32'h304, 3'd1, 64'd5, 3'd1, 32'd5));
    wait_acc();
    put(mk(32'h00600093, 32'h308, 3'd1, 64'd6, 3'd1, 32'd6));
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_valid", 64'(a_ov), 64'd0);
    chk("t4_ready", 64'(a_ir), 64'd1);

    // flush with room: the accepted-looking beat must still be dropped
    put(mk(32'h00700093, 32'h30C, 3'd1, 64'd7, 3'd1, 32'd7));
    wait_acc();
    put(mk(32'h00800093, 32'h310, 3'd1, 64'd8, 3'd1, 32'd8));
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    chk("t4b_valid", 64'(a_ov), 64'd0);

    // random handshake stream with a reset pulse in the middle
    pending = 1'b0;
    n_acc = 0;
    pc = 32'h1000;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      if (c == 400) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        pending = 1'b0;
        #1;
        chk("rst_mid_valid64", 64'(a_ov), 64'd0);
        chk("rst_mid_valid32", 64'(b_ov), 64'd0);
        chk("rst_mid_ready", 64'(a_ir), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      if (!pending && $urandom_range(0, 3) != 0) begin
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
        put(model(r, pc));
        pc = pc + 32'd4;
        pending = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && a_ir;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        pending = 1'b0;
        in_valid = 1'b0;
      end
    end
    chk("rand_count", 64'(n_acc), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles(4);
    chk("rand_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
